uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Byte buffer that sits directly upstream of the uart transmitter. It accepts bytes from a producer with a single-cycle write strobe, stores them in a circular FIFO, and presents them one at a time on the uart's tx_data / tx_req / tx_ack four-phase handshake. This decouples bursty producers from the slow serial link and removes per-byte handshake logic from every client.

Parameters:
DEPTH, 16, number of byte entries; power of two, minimum 2
ADDR_W, 4, pointer width; must equal log2(DEPTH)

Ports:
inclk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
wr_en  input  1  producer write strobe, sampled each rising edge
wr_data  input  8  byte to enqueue, valid when wr_en=1
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
count  output  ADDR_W+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was attempted while full
ovf_clr  input  1  clears overflow
tx_data  output  8  byte offered to uart, registered
tx_req  output  1  request to uart, registered
tx_ack  input  1  uart has captured tx_data

Behaviour:
- Reset (rst=1 at a rising edge): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, overflow=0, tx_req=0, tx_data=8'h00, state=IDLE. Reset applies mid-handshake too: the in-flight byte and all stored bytes are discarded, and tx_req is 0 after that edge.
- Storage: DEPTH x 8 register array; pointers wrap modulo DEPTH (DEPTH-1 -> 0).
- Flags are combinational from count: full = (count==DEPTH), empty = (count==0).
- Write: accepted when wr_en=1 and full=0. mem[wr_ptr] <= wr_data, wr_ptr++, count++.
- Write while full: the byte is dropped, pointers and count are unchanged, and overflow <= 1.
- overflow: set by a dropped write; cleared by ovf_clr=1. If a dropped write and ovf_clr occur in the same cycle, set wins.
- Pop: occurs only on the handshake-complete edge (see REQ state). rd_ptr++, count--.
- Simultaneous accepted write and pop in the same cycle: count is unchanged and both pointers advance.
- Simultaneous write while full and pop in the same cycle: the write is dropped and overflow is set. full is evaluated on the pre-edge count; there is no write-through.
- Handshake FSM, three states:
  - IDLE: tx_req=0. If empty=0, then tx_data <= mem[rd_ptr], tx_req <= 1, go to REQ.
  - REQ: tx_req=1 and tx_data is held stable. When tx_ack=1, pop, tx_req <= 0, go to WAIT_LOW.
  - WAIT_LOW: tx_req=0. Stay here until tx_ack=0, then go to IDLE.
- A byte is never re-offered, and tx_req never asserts while tx_ack is still high.
- Latency, write into empty FIFO in IDLE: the write is accepted at edge k (count=1 after k). tx_req=1 and tx_data are valid after edge k+1.
- Back-to-back bytes: minimum 3 edges between successive tx_req rising transitions (REQ -> WAIT_LOW -> IDLE -> REQ), assuming tx_ack falls the cycle after tx_req falls.
- tx_ack=1 while in IDLE or WAIT_LOW is ignored: no pop and no state change, except that WAIT_LOW exits only on tx_ack=0.
- The FIFO entry is not popped while in REQ. count therefore includes the byte currently offered until its ack.
- tx_data retains its last value when tx_req=0.

Test Plan:
1. Reset then single write: rst for 8 cycles, then wr_en=1, wr_data=8'hA5 for one cycle -> count=1 next cycle, tx_req=1 with tx_data=8'hA5 one edge later. Uart ack -> tx_req=0, count=0, empty=1.
2. Burst and ordering: write 8'h01..8'h10 on 16 consecutive cycles (DEPTH=16), with the uart model stalled (tx_ack held 0) -> full=1, count=16. Release the uart -> tx_data sequence is exactly 01..10, and empty=1 after the 16th ack.
3. Overflow: with full=1, write 8'hEE -> byte not stored, count stays 16, overflow=1. Pulse ovf_clr -> overflow=0. Drain the FIFO -> 8'hEE never appears.
4. Simultaneous write and pop: hold count=5 and write on the exact edge where tx_ack completes the pop -> count stays 5 and both wr_ptr and rd_ptr advance. Check wrap-around by running 40 bytes through the FIFO with scoreboard ordering intact.
5. Handshake discipline: uart model holds tx_ack=1 for 4 cycles after tx_req falls -> FSM stays in WAIT_LOW, and tx_req does not reassert until the cycle after tx_ack=0, even though the FIFO is non-empty.
6. Reset mid-operation: assert rst while tx_req=1 and count=3 -> after that edge tx_req=0, count=0, empty=1, overflow=0. After reset deasserts, write 8'h3C -> it is the next byte offered.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a uart transmitter over a tx_req/tx_ack four-phase handshake.
// Bytes are popped only when the uart acknowledges, so count includes the byte on offer.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              inclk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic [7:0]        tx_data,
  output logic              tx_req,
  input  logic              tx_ack
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              wr_acc, wr_drop, pop, load;

  // Flags use the pre-edge count, so a write while full is dropped even if a pop lands on the same edge.
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign wr_acc  = wr_en && !full;
  assign wr_drop = wr_en && full;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          load      = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (tx_ack) begin
          pop       = 1'b1;
          state_nxt = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!tx_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge inclk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_req   <= 1'b0;
      tx_data  <= '0;
    end else begin
      state  <= state_nxt;
      tx_req <= (state_nxt == REQ);
      if (load)   tx_data <= mem[rd_ptr];
      if (wr_acc) wr_ptr  <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr  <= rd_ptr + PTR_ONE;
      case ({wr_acc, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (wr_drop)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge inclk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: directed writes push expected bytes, a monitor
// checks each byte offered on tx_req against the queue while a uart model acknowledges.
module tb_uart_tx_fifo;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              inclk;
  logic              rst;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              ovf_clr;
  logic [7:0]        tx_data;
  logic              tx_req;
  logic              tx_ack;

  int         tests;
  int         fails;
  logic [7:0] sb [$];
  bit         stall;
  int         ack_hold;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .inclk    (inclk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .tx_ack   (tx_ack)
  );

  initial inclk = 1'b0;
  always #5 inclk = ~inclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge inclk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d, input bit stored);
    wr_en   = 1'b1;
    wr_data = d;
    if (stored) sb.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (!(sb.size() == 0 && empty && !tx_req && !tx_ack) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: actual count=%0d pending=%0d required drained", name, count, sb.size());
    end
    tick();
    check({name, "_count"}, 32'(count), 32'd0);
    check({name, "_empty"}, 32'(empty), 32'd1);
  endtask

  // Uart model: acks a request, then holds ack for ack_hold cycles after tx_req falls.
  initial begin : uart_model
    int hold_cnt;
    hold_cnt = 0;
    tx_ack   = 1'b0;
    forever begin
      @(negedge inclk);
      if (rst) begin
        tx_ack   = 1'b0;
        hold_cnt = 0;
      end else if (tx_ack) begin
        if (!tx_req) begin
          if (hold_cnt >= ack_hold) begin
            tx_ack   = 1'b0;
            hold_cnt = 0;
          end else begin
            hold_cnt++;
          end
        end
      end else if (tx_req && !stall) begin
        tx_ack = 1'b1;
      end
    end
  end

  initial begin : monitor
    logic       prev_req;
    logic [7:0] cur;
    prev_req = 1'b0;
    cur      = '0;
    forever begin
      @(posedge inclk);
      #1;
      if (rst) begin
        prev_req = 1'b0;
      end else begin
        if (tx_req && !prev_req) begin
          check("req_rise_ack_low", 32'(tx_ack), 32'd0);
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_byte: actual=%0h required=none", tx_data);
          end else begin
            cur = sb.pop_front();
            check("tx_data_order", 32'(tx_data), 32'(cur));
          end
        end else if (tx_req) begin
          check("tx_data_stable", 32'(tx_data), 32'(cur));
        end
        prev_req = tx_req;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    tests    = 0;
    fails    = 0;
    stall    = 1'b1;
    ack_hold = 0;
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_data  = '0;
    ovf_clr  = 1'b0;

    // 1: reset state, single write latency, ack
    repeat (8) tick();
    check("rst_count",    32'(count),    32'd0);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_full",     32'(full),     32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_tx_req",   32'(tx_req),   32'd0);
    check("rst_tx_data",  32'(tx_data),  32'h00);
    rst = 1'b0;
    tick();
    write_byte(8'hA5, 1'b1);
    check("t1_count_k",  32'(count),  32'd1);
    check("t1_req_k",    32'(tx_req), 32'd0);
    check("t1_empty_k",  32'(empty),  32'd0);
    tick();
    check("t1_req_k1",   32'(tx_req),  32'd1);
    check("t1_data_k1",  32'(tx_data), 32'hA5);
    stall = 1'b0;
    tick();
    check("t1_req_ack",   32'(tx_req), 32'd0);
    check("t1_count_ack", 32'(count),  32'd0);
    check("t1_empty_ack", 32'(empty),  32'd1);
    wait_drain("t1");

    // 2: burst fill with uart stalled
    stall = 1'b1;
    for (int i = 1; i <= 16; i++) write_byte(8'(i), 1'b1);
    check("t2_full",  32'(full),  32'd1);
    check("t2_count", 32'(count), 32'd16);
    check("t2_empty", 32'(empty), 32'd0);

    // 3: overflow, clear priority, drop on simultaneous pop
    write_byte(8'hEE, 1'b0);
    check("t3_count_drop", 32'(count),    32'd16);
    check("t3_ovf_set",    32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t3_ovf_clr", 32'(overflow), 32'd0);
    ovf_clr = 1'b1;
    write_byte(8'hEE, 1'b0);
    ovf_clr = 1'b0;
    check("t3_ovf_set_wins", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t3_ovf_clr2", 32'(overflow), 32'd0);
    stall = 1'b0;
    write_byte(8'hEE, 1'b0);
    check("t3_count_pop_drop", 32'(count),    32'd15);
    check("t3_ovf_pop_drop",   32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t3_ovf_clr3", 32'(overflow), 32'd0);
    wait_drain("t3");
    check("t3_tx_data_held", 32'(tx_data), 32'h10);
    check("t3_req_low",      32'(tx_req),  32'd0);

    // 4: write on the pop edge at count=5, then 40 bytes through the ring
    stall = 1'b1;
    for (int i = 0; i < 5; i++) write_byte(8'(8'h50 + i), 1'b1);
    check("t4_count5", 32'(count),  32'd5);
    check("t4_req",    32'(tx_req), 32'd1);
    stall = 1'b0;
    write_byte(8'h55, 1'b1);
    check("t4_count_same", 32'(count),  32'd5);
    check("t4_req_pop",    32'(tx_req), 32'd0);
    wait_drain("t4a");
    for (int i = 0; i < 40; i++) begin
      write_byte(8'(i * 11 + 7), 1'b1);
      repeat (3) tick();
    end
    wait_drain("t4b");

    // 5: ack held high for 4 cycles after tx_req falls
    stall    = 1'b1;
    ack_hold = 4;
    write_byte(8'h60, 1'b1);
    write_byte(8'h61, 1'b1);
    write_byte(8'h62, 1'b1);
    stall = 1'b0;
    n = 0;
    while (!(tx_ack && !tx_req) && n < 20) begin
      tick();
      n++;
    end
    check("t5_ack_seen", 32'(tx_ack && !tx_req), 32'd1);
    n = 0;
    while (tx_ack && n < 20) begin
      check("t5_req_hold", 32'(tx_req), 32'd0);
      check("t5_count_hold", 32'(count), 32'd2);
      tick();
      n++;
    end
    check("t5_hold_cycles", 32'(n), 32'd5);
    check("t5_req_after_fall", 32'(tx_req), 32'd0);
    tick();
    check("t5_req_reassert", 32'(tx_req), 32'd1);
    wait_drain("t5");
    ack_hold = 0;

    // 6: reset while a byte is on offer
    stall = 1'b1;
    write_byte(8'h70, 1'b1);
    write_byte(8'h71, 1'b1);
    write_byte(8'h72, 1'b1);
    check("t6_pre_req",   32'(tx_req), 32'd1);
    check("t6_pre_count", 32'(count),  32'd3);
    rst = 1'b1;
    tick();
    check("t6_req",      32'(tx_req),   32'd0);
    check("t6_count",    32'(count),    32'd0);
    check("t6_empty",    32'(empty),    32'd1);
    check("t6_overflow", 32'(overflow), 32'd0);
    sb.delete();
    rst = 1'b0;
    tick();
    stall = 1'b0;
    write_byte(8'h3C, 1'b1);
    wait_drain("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
